// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared state/opcode types and default widths for the sequenced datapath.
package dp_seq_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_OWIDTH = 32;
  typedef enum logic [2:0] {IDLE, ADD_D, ADD_E, SUB_F, CMP, SEL, SHIFT} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_CMP} op_t;
endpackage

// File: rtl/dp_seq_alu.sv
// dp_seq_alu: shared combinational add/sub/compare unit time-multiplexed by the controller.
module dp_seq_alu
  import dp_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] res,
  output logic             lt,
  output logic             eq
);
  always_comb begin
    res = op == OP_SUB ? opa - opb : op == OP_ADD ? opa + opb : '0;
    lt = opa < opb;
    eq = opa == opb;
  end
endmodule

// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: six-step sequencer computing x/z from a/b/c through one shared ALU.
module dp_seq_ctrl
  import dp_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OWIDTH = DEF_OWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  output logic              busy,
  output logic              done,
  output logic [OWIDTH-1:0] x,
  output logic [OWIDTH-1:0] z
);
  state_t state, next;
  op_t op;
  logic [WIDTH-1:0] ra, rb, rc, d, e, f, g, h, opa, opb, res, sel_g;
  logic lt, eq, alu_lt, alu_eq;

  dp_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op(op), .opa(opa), .opb(opb), .res(res), .lt(alu_lt), .eq(alu_eq)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;

  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = start ? ADD_D : IDLE;
      ADD_D:   next = ADD_E;
      ADD_E:   next = SUB_F;
      SUB_F:   next = CMP;
      CMP:     next = SEL;
      SEL:     next = SHIFT;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    op = state == SUB_F ? OP_SUB : state == CMP ? OP_CMP : OP_ADD;
    opa = state == CMP ? d : ra;
    opb = state == ADD_E ? rc : state == CMP ? e : rb;
  end

  assign sel_g = lt ? d : e;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {ra, rb, rc, d, e, f, g, h} <= '0;
      {lt, eq, done} <= '0;
      x <= '0;
      z <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          rc <= c;
        end
        ADD_D: d <= res;
        ADD_E: e <= res;
        SUB_F: f <= res;
        CMP: begin
          lt <= alu_lt;
          eq <= alu_eq;
        end
        SEL: begin
          g <= sel_g;
          h <= eq ? sel_g : f;
        end
        SHIFT: begin
          x <= OWIDTH'(h << lt);
          z <= OWIDTH'(g >> eq);
        end
        default: ;
      endcase
      done <= state == SHIFT;
    end
endmodule
